// File: rtl/button_conditioner.sv
// Push-button front end: two-flop synchroniser, press/release debounce FSM,
// long-press detection and auto-repeat step events, all on clknew.
module button_conditioner #(
    parameter int   DEBOUNCE_CYCLES   = 4,
    parameter int   LONG_PRESS_CYCLES = 10,
    parameter int   REPEAT_CYCLES     = 5,
    parameter int   CNT_W             = 20,
    parameter logic ACTIVE_LOW        = 1'b0
) (
    input  logic clknew,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press,
    output logic step_pulse
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        HELD        = 2'd2,
        ARM_RELEASE = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             btn_in;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             btn_level_q, btn_level_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;
    logic             long_press_q, long_press_d;
    logic             step_pulse_q, step_pulse_d;

    assign btn_in = btn_raw ^ ACTIVE_LOW;

    always_comb begin
        s1_d            = btn_in;
        s2_d            = s1_q;
        state_d         = state_q;
        dcnt_d          = dcnt_q;
        hold_cnt_d      = hold_cnt_q;
        rep_cnt_d       = rep_cnt_q;
        btn_level_d     = btn_level_q;
        long_press_d    = long_press_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        step_pulse_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = ARM_PRESS;
                    dcnt_d  = '0;
                end
            end
            ARM_PRESS: begin
                if (!s2_q) begin
                    state_d = IDLE;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d       = HELD;
                    press_pulse_d = 1'b1;
                    step_pulse_d  = 1'b1;
                    btn_level_d   = 1'b1;
                    hold_cnt_d    = '0;
                    rep_cnt_d     = '0;
                end else begin
                    dcnt_d = dcnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!s2_q) begin
                    state_d = ARM_RELEASE;
                    dcnt_d  = '0;
                end else if (!long_press_q) begin
                    // hold_cnt stops once the long-press threshold fires
                    if (hold_cnt_q == LONG_LAST) begin
                        long_press_d = 1'b1;
                        step_pulse_d = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_ONE;
                    end
                end else if (rep_cnt_q == REP_LAST) begin
                    rep_cnt_d    = '0;
                    step_pulse_d = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + CNT_ONE;
                end
            end
            ARM_RELEASE: begin
                // hold/repeat counters stay frozen here so a glitch only delays them
                if (s2_q) begin
                    state_d = HELD;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d         = IDLE;
                    release_pulse_d = 1'b1;
                    btn_level_d     = 1'b0;
                    long_press_d    = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clknew) begin
        if (!rst_n) begin
            s1_q            <= 1'b0;
            s2_q            <= 1'b0;
            state_q         <= IDLE;
            dcnt_q          <= '0;
            hold_cnt_q      <= '0;
            rep_cnt_q       <= '0;
            btn_level_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_press_q    <= 1'b0;
            step_pulse_q    <= 1'b0;
        end else begin
            s1_q            <= s1_d;
            s2_q            <= s2_d;
            state_q         <= state_d;
            dcnt_q          <= dcnt_d;
            hold_cnt_q      <= hold_cnt_d;
            rep_cnt_q       <= rep_cnt_d;
            btn_level_q     <= btn_level_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_press_q    <= long_press_d;
            step_pulse_q    <= step_pulse_d;
        end
    end

    assign btn_level     = btn_level_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_press    = long_press_q;
    assign step_pulse    = step_pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: active-high and active-low instances driven with
// the same logical press, checked every cycle against a behavioural model.
module tb_button_conditioner;

    localparam int D = 4;
    localparam int L = 10;
    localparam int R = 5;

    logic clknew = 1'b0;
    logic rst_n  = 1'b0;
    logic raw_a  = 1'b0;
    logic raw_b  = 1'b1;
    logic lvl_a, pp_a, rp_a, lp_a, sp_a;
    logic lvl_b, pp_b, rp_b, lp_b, sp_b;

    always #5 clknew = ~clknew;

    button_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(R),
                         .CNT_W(20), .ACTIVE_LOW(1'b0)) dut_a (
        .clknew(clknew), .rst_n(rst_n), .btn_raw(raw_a), .btn_level(lvl_a),
        .press_pulse(pp_a), .release_pulse(rp_a), .long_press(lp_a), .step_pulse(sp_a));

    button_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(R),
                         .CNT_W(20), .ACTIVE_LOW(1'b1)) dut_b (
        .clknew(clknew), .rst_n(rst_n), .btn_raw(raw_b), .btn_level(lvl_b),
        .press_pulse(pp_b), .release_pulse(rp_b), .long_press(lp_b), .step_pulse(sp_b));

    logic [4:0] out_a, out_b, exp_v;
    assign out_a = {lvl_a, pp_a, rp_a, lp_a, sp_a};
    assign out_b = {lvl_b, pp_b, rp_b, lp_b, sp_b};

    int vectors = 0;
    int errors  = 0;

    // Reference model: a press/release is accepted after D+1 consecutive
    // synchronised samples disagreeing with the current level; n counts
    // uninterrupted "still held" samples since the press.
    bit m_s1, m_s2, m_pressed;
    int m_run, m_n;
    bit e_lvl, e_pp, e_rp, e_lp, e_sp;
    assign exp_v = {e_lvl, e_pp, e_rp, e_lp, e_sp};

    function automatic void model_step(input bit press, input bit rst_val);
        bit s2_seen;
        int prev_run;
        e_pp = 1'b0; e_rp = 1'b0; e_sp = 1'b0;
        if (!rst_val) begin
            m_s1 = 0; m_s2 = 0; m_pressed = 0; m_run = 0; m_n = 0;
            e_lvl = 0; e_lp = 0;
            return;
        end
        s2_seen  = m_s2;
        m_s2     = m_s1;
        m_s1     = press;
        prev_run = m_run;
        if (s2_seen != m_pressed) begin
            m_run = m_run + 1;
            if (m_run == D + 1) begin
                m_pressed = ~m_pressed;
                if (m_pressed) begin e_pp = 1; e_sp = 1; end
                else e_rp = 1;
                m_n   = 0;
                m_run = 0;
            end
        end else begin
            if (m_pressed && prev_run == 0) begin
                m_n = m_n + 1;
                if (m_n == L || (m_n > L && (m_n - L) % R == 0)) e_sp = 1;
            end
            m_run = 0;
        end
        e_lvl = m_pressed;
        e_lp  = m_pressed && (m_n >= L);
    endfunction

    task automatic tick(input bit press, input bit rst_val);
        @(negedge clknew);
        rst_n = rst_val;
        raw_a = press;
        raw_b = ~press;
        @(posedge clknew);
        model_step(press, rst_val);
        #1;
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) begin
            tick(1'b0, 1'b1);
            vectors += 2;
            if (out_a !== exp_v) begin errors++; $display("FAIL settle dut_a k=%0d got=%b exp=%b", k, out_a, exp_v); end
            if (out_b !== exp_v) begin errors++; $display("FAIL settle dut_b k=%0d got=%b exp=%b", k, out_b, exp_v); end
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0);
            vectors += 2;
            if (out_a !== 5'b0) begin errors++; $display("FAIL reset dut_a k=%0d got=%b exp=00000", k, out_a); end
            if (out_b !== 5'b0) begin errors++; $display("FAIL reset dut_b k=%0d got=%b exp=00000", k, out_b); end
        end
        settle(8);
    endtask

    task automatic test_basic();
        int press_e = -1, rel_e = -1, lvl_hi = 0;
        for (int k = 0; k < 45; k++) begin
            tick(k < 30, 1'b1);
            vectors += 2;
            if (out_a !== exp_v) begin errors++; $display("FAIL basic dut_a k=%0d got=%b exp=%b", k, out_a, exp_v); end
            if (out_b !== exp_v) begin errors++; $display("FAIL basic dut_b k=%0d got=%b exp=%b", k, out_b, exp_v); end
            if (pp_a && press_e < 0) press_e = k;
            if (rp_a && rel_e < 0) rel_e = k;
            if (k == 20) lvl_hi = lvl_a;
        end
        vectors += 3;
        if (press_e !== 6) begin errors++; $display("FAIL basic_press_edge got=%0d exp=6", press_e); end
        if (rel_e !== 36) begin errors++; $display("FAIL basic_release_edge got=%0d exp=36", rel_e); end
        if (lvl_hi !== 1) begin errors++; $display("FAIL basic_level_held got=%0d exp=1", lvl_hi); end
        settle(5);
    endtask

    task automatic test_bounce();
        bit [6:0] seq = 7'b0110111; // bit k = sample at edge k: 1,1,1,0,1,1,0
        int presses = 0, press_e = -1;
        for (int k = 0; k < 35; k++) begin
            tick((k < 7) ? seq[k] : (k < 25), 1'b1);
            vectors += 2;
            if (out_a !== exp_v) begin errors++; $display("FAIL bounce dut_a k=%0d got=%b exp=%b", k, out_a, exp_v); end
            if (out_b !== exp_v) begin errors++; $display("FAIL bounce dut_b k=%0d got=%b exp=%b", k, out_b, exp_v); end
            if (pp_a) begin presses++; if (press_e < 0) press_e = k; end
        end
        vectors += 2;
        if (presses !== 1) begin errors++; $display("FAIL bounce_press_count got=%0d exp=1", presses); end
        if (press_e !== 13) begin errors++; $display("FAIL bounce_press_edge got=%0d exp=13", press_e); end
        settle(5);
    endtask

    task automatic test_long_press();
        int exp_steps[6] = '{6, 16, 21, 26, 31, 36};
        int steps[$];
        int lp_first = -1, lp_last = -1, rel_e = -1;
        for (int k = 0; k < 52; k++) begin
            tick(k < 38, 1'b1);
            vectors += 2;
            if (out_a !== exp_v) begin errors++; $display("FAIL long dut_a k=%0d got=%b exp=%b", k, out_a, exp_v); end
            if (out_b !== exp_v) begin errors++; $display("FAIL long dut_b k=%0d got=%b exp=%b", k, out_b, exp_v); end
            if (sp_a) steps.push_back(k);
            if (lp_a) begin if (lp_first < 0) lp_first = k; lp_last = k; end
            if (rp_a && rel_e < 0) rel_e = k;
        end
        vectors += 4;
        if (steps.size() !== 6) begin errors++; $display("FAIL long_step_count got=%0d exp=6", steps.size()); end
        else for (int i = 0; i < 6; i++)
            if (steps[i] !== exp_steps[i]) begin errors++; $display("FAIL long_step_edge i=%0d got=%0d exp=%0d", i, steps[i], exp_steps[i]); end
        if (lp_first !== 16) begin errors++; $display("FAIL long_first got=%0d exp=16", lp_first); end
        if (rel_e !== 44) begin errors++; $display("FAIL long_release_edge got=%0d exp=44", rel_e); end
        if (lp_last !== 43) begin errors++; $display("FAIL long_clear_edge got=%0d exp=43", lp_last); end
        settle(5);
    endtask

    task automatic test_glitch();
        int exp_steps[5] = '{6, 16, 21, 29, 34};
        int steps[$];
        int presses = 0, rels = 0, rel_e = -1;
        for (int k = 0; k < 50; k++) begin
            tick((k < 36) && (k != 23) && (k != 24), 1'b1);
            vectors += 2;
            if (out_a !== exp_v) begin errors++; $display("FAIL glitch dut_a k=%0d got=%b exp=%b", k, out_a, exp_v); end
            if (out_b !== exp_v) begin errors++; $display("FAIL glitch dut_b k=%0d got=%b exp=%b", k, out_b, exp_v); end
            if (sp_a) steps.push_back(k);
            if (pp_a) presses++;
            if (rp_a) begin rels++; rel_e = k; end
        end
        vectors += 4;
        if (steps.size() !== 5) begin errors++; $display("FAIL glitch_step_count got=%0d exp=5", steps.size()); end
        else for (int i = 0; i < 5; i++)
            if (steps[i] !== exp_steps[i]) begin errors++; $display("FAIL glitch_step_edge i=%0d got=%0d exp=%0d", i, steps[i], exp_steps[i]); end
        if (presses !== 1) begin errors++; $display("FAIL glitch_press_count got=%0d exp=1", presses); end
        if (rels !== 1) begin errors++; $display("FAIL glitch_release_count got=%0d exp=1", rels); end
        if (rel_e !== 42) begin errors++; $display("FAIL glitch_release_edge got=%0d exp=42", rel_e); end
        settle(5);
    endtask

    task automatic test_reset_mid_held();
        int press_e = -1;
        for (int k = 0; k < 12; k++) tick(1'b1, 1'b1);
        vectors += 1;
        if (lvl_a !== 1'b1) begin errors++; $display("FAIL rsthold_pre_level got=%0d exp=1", lvl_a); end
        tick(1'b1, 1'b0);
        vectors += 2;
        if (out_a !== 5'b0) begin errors++; $display("FAIL rsthold_clear dut_a got=%b exp=00000", out_a); end
        if (out_b !== 5'b0) begin errors++; $display("FAIL rsthold_clear dut_b got=%b exp=00000", out_b); end
        for (int k = 0; k < 12; k++) begin
            tick(1'b1, 1'b1);
            vectors += 2;
            if (out_a !== exp_v) begin errors++; $display("FAIL rsthold dut_a k=%0d got=%b exp=%b", k, out_a, exp_v); end
            if (out_b !== exp_v) begin errors++; $display("FAIL rsthold dut_b k=%0d got=%b exp=%b", k, out_b, exp_v); end
            if (pp_a && press_e < 0) press_e = k;
        end
        vectors += 1;
        if (press_e !== 6) begin errors++; $display("FAIL rsthold_press_edge got=%0d exp=6", press_e); end
        settle(12);
    endtask

    task automatic test_active_low();
        int events = 0, press_e = -1, rel_e = -1;
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, 1'b1);
            vectors += 1;
            if (out_b !== 5'b0) begin errors++; $display("FAIL actlow_idle k=%0d got=%b exp=00000", k, out_b); end
        end
        for (int k = 0; k < 42; k++) begin
            tick(k < 30, 1'b1);
            vectors += 1;
            if (out_b !== exp_v) begin errors++; $display("FAIL actlow dut_b k=%0d got=%b exp=%b", k, out_b, exp_v); end
            if (pp_b && press_e < 0) press_e = k;
            if (rp_b && rel_e < 0) rel_e = k;
            if (pp_b) events++;
        end
        vectors += 3;
        if (press_e !== 6) begin errors++; $display("FAIL actlow_press_edge got=%0d exp=6", press_e); end
        if (rel_e !== 36) begin errors++; $display("FAIL actlow_release_edge got=%0d exp=36", rel_e); end
        if (events !== 1) begin errors++; $display("FAIL actlow_press_count got=%0d exp=1", events); end
        settle(5);
    endtask

    task automatic test_random();
        for (int s = 0; s < 60; s++) begin
            bit lvl = 1'($urandom_range(0, 1));
            int len = int'($urandom_range(1, 14));
            bit rs  = ($urandom_range(0, 14) == 0);
            for (int k = 0; k < len; k++) begin
                tick(lvl, !(rs && k == 0));
                vectors += 2;
                if (out_a !== exp_v) begin errors++; $display("FAIL random dut_a s=%0d k=%0d got=%b exp=%b", s, k, out_a, exp_v); end
                if (out_b !== exp_v) begin errors++; $display("FAIL random dut_b s=%0d k=%0d got=%b exp=%b", s, k, out_b, exp_v); end
            end
        end
        settle(10);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bounce();
        test_long_press();
        test_glitch();
        test_reset_mid_held();
        test_active_low();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
